// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment encoding for the scanned 7-segment display path.
// Segment vectors are active-low {p,g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [7:0] segVec_t;

    localparam segVec_t SEG_BLANK = 8'hFF;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;

    // Entry [n] is the active-low {g..a} pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Producer-side bus of the scan driver: digit data, load strobe, brightness
// and the busy flag that reports an uncommitted pending buffer.
interface seg7_scan_driver_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);

    logic [4*DIGITS-1:0] hexs;
    logic [DIGITS-1:0]   points;
    logic [DIGITS-1:0]   LEs;
    logic [DIGITS-1:0]   blink;
    logic                load;
    logic [BRIGHT_W-1:0] bright;
    logic                busy;

    modport master (
        output hexs, points, LEs, blink, load, bright,
        input  busy
    );

    modport slave (
        input  hexs, points, LEs, blink, load, bright,
        output busy
    );

endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex digit + decimal point to active-low segment vector.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       point,
    output segVec_t    seg
);

    always_comb begin
        seg               = SEG_BLANK;
        seg[SEG_G:SEG_A]  = HEX_SEG_TABLE[hex];
        seg[SEG_P]        = ~point;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed 7-segment driver with double-buffered data,
// per-digit blink/blank and PWM brightness inside each digit slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_LOG2    = 17,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus,
    output logic                frame,
    output logic [DIGITS-1:0]   AN,
    output logic [7:0]          SEGMENT
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int BFC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [BFC_W-1:0] LAST_BF  = BFC_W'(BLINK_FRAMES - 1);

    logic [SCAN_LOG2-1:0] prescaler;
    logic [IDX_W-1:0]     digitIdx;
    logic [BFC_W-1:0]     blinkCnt;
    logic                 blinkPhase;

    logic [4*DIGITS-1:0]  pendHexs,   dispHexs;
    logic [DIGITS-1:0]    pendPoints, dispPoints;
    logic [DIGITS-1:0]    pendLEs,    dispLEs;
    logic [DIGITS-1:0]    pendBlink,  dispBlink;
    logic                 busyQ;

    logic                 slotEnd;
    logic                 frameEnd;
    logic                 dutyOn;
    logic                 visible;
    logic [3:0]           curHex;
    logic                 curPoint;
    segVec_t              curSeg;

    assign slotEnd  = &prescaler;
    assign frameEnd = slotEnd && (digitIdx == LAST_IDX);

    // With bright below full scale the top prescaler bits are all ones on the
    // slot_end cycle, so duty_on is already low there; the explicit slotEnd
    // term covers full brightness and keeps AN blank across every index change.
    assign dutyOn   = (&bus.bright) || (prescaler[SCAN_LOG2-1 -: BRIGHT_W] < bus.bright);
    assign visible  = dutyOn && !slotEnd && !dispLEs[digitIdx]
                      && !(dispBlink[digitIdx] && blinkPhase);

    assign curHex   = dispHexs[4*digitIdx +: 4];
    assign curPoint = dispPoints[digitIdx];
    assign bus.busy = busyQ;

    seg7_hex_decode uDecode (
        .hex   (curHex),
        .point (curPoint),
        .seg   (curSeg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler  <= '0;
            digitIdx   <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            frame      <= 1'b0;
        end else begin
            prescaler <= prescaler + SCAN_LOG2'(1);
            frame     <= frameEnd;
            if (slotEnd) begin
                digitIdx <= (digitIdx == LAST_IDX) ? '0 : digitIdx + IDX_W'(1);
            end
            if (frameEnd) begin
                if (blinkCnt == LAST_BF) begin
                    blinkCnt   <= '0;
                    blinkPhase <= ~blinkPhase;
                end else begin
                    blinkCnt <= blinkCnt + BFC_W'(1);
                end
            end
        end
    end

    // A load coinciding with frame_end still commits the older pending copy;
    // the fresh data stays pending and busy remains set for another frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pendHexs   <= '0;
            pendPoints <= '0;
            pendLEs    <= '0;
            pendBlink  <= '0;
            dispHexs   <= '0;
            dispPoints <= '0;
            dispLEs    <= '0;
            dispBlink  <= '0;
            busyQ      <= 1'b0;
        end else begin
            if (frameEnd && busyQ) begin
                dispHexs   <= pendHexs;
                dispPoints <= pendPoints;
                dispLEs    <= pendLEs;
                dispBlink  <= pendBlink;
            end
            if (bus.load) begin
                pendHexs   <= bus.hexs;
                pendPoints <= bus.points;
                pendLEs    <= bus.LEs;
                pendBlink  <= bus.blink;
                busyQ      <= 1'b1;
            end else if (frameEnd) begin
                busyQ      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            AN      <= '1;
            SEGMENT <= SEG_BLANK;
        end else begin
            AN      <= visible ? ~(DIGITS'(1) << digitIdx) : '1;
            SEGMENT <= visible ? curSeg : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 16-cycle slots,
// 2-bit brightness, 2-frame blink half-period) against a cycle-count model.
module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_LOG2    = 4;
    localparam int BRIGHT_W     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int SLOT         = 1 << SCAN_LOG2;
    localparam int FRAME        = SLOT * DIGITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

    seg7_scan_driver #(
        .DIGITS       (DIGITS),
        .SCAN_LOG2    (SCAN_LOG2),
        .BRIGHT_W     (BRIGHT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .frame   (frame),
        .AN      (AN),
        .SEGMENT (SEGMENT)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Reference model: everything about scan position, blink phase and
    // brightness is derived from the count of clocks since reset release.
    int          cyc;
    logic [15:0] mPendHex, mDispHex;
    logic [3:0]  mPendPts, mDispPts, mPendLE, mDispLE, mPendBlk, mDispBlk;
    logic        mBusy;
    logic [3:0]  expAn;
    logic [7:0]  expSeg;
    logic        expFrame;

    int          mp, md;
    logic        mfEnd, mPhase, mLit, mVis;
    logic [3:0]  mAn;
    logic [7:0]  mSeg;

    always_comb begin
        mp     = cyc % SLOT;
        md     = (cyc / SLOT) % DIGITS;
        mfEnd  = (cyc % FRAME) == FRAME - 1;
        mPhase = (((cyc / FRAME) / BLINK_FRAMES) % 2) == 1;
        if (bus.bright == 2'd3) mLit = (mp != SLOT - 1);
        else                    mLit = (mp / 4) < int'(bus.bright);
        mVis = mLit && !mDispLE[md] && !(mDispBlk[md] && mPhase);
        mAn  = 4'hF;
        mSeg = 8'hFF;
        if (mVis) begin
            mAn  = ~(4'b0001 << md);
            mSeg = {~mDispPts[md], hexSeg(mDispHex[md*4 +: 4])};
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            cyc      <= 0;
            mPendHex <= '0; mPendPts <= '0; mPendLE <= '0; mPendBlk <= '0;
            mDispHex <= '0; mDispPts <= '0; mDispLE <= '0; mDispBlk <= '0;
            mBusy    <= 1'b0;
            expAn    <= 4'hF;
            expSeg   <= 8'hFF;
            expFrame <= 1'b0;
        end else begin
            expAn    <= mAn;
            expSeg   <= mSeg;
            expFrame <= mfEnd;
            cyc      <= cyc + 1;
            if (mfEnd && mBusy) begin
                mDispHex <= mPendHex; mDispPts <= mPendPts;
                mDispLE  <= mPendLE;  mDispBlk <= mPendBlk;
            end
            if (bus.load) begin
                mPendHex <= bus.hexs; mPendPts <= bus.points;
                mPendLE  <= bus.LEs;  mPendBlk <= bus.blink;
                mBusy    <= 1'b1;
            end else if (mfEnd) begin
                mBusy    <= 1'b0;
            end
        end
    end

    task automatic advance_to(input int phaseInFrame);
        int n = 0;
        while ((cyc % FRAME) != phaseInFrame && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int firstFrame = 0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (AN !== 4'hF || SEGMENT !== 8'hFF || bus.busy !== 1'b0 || frame !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold AN=%h SEG=%h busy=%b frame=%b required F FF 0 0",
                         AN, SEGMENT, bus.busy, frame);
            end
        end
        rst = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL reset_run cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            if (frame === 1'b1 && firstFrame == 0) firstFrame = n;
        end
        checks++;
        if (firstFrame != 64) begin
            errors++;
            $display("FAIL first_frame got cycle %0d required 64", firstFrame);
        end
    endtask

    task automatic test_load_commit();
        logic [7:0] want [4] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
        int lit [4] = '{0, 0, 0, 0};
        int n = 0;
        bus.bright = 2'd3;
        advance_to(20);
        bus.hexs = 16'h1234; bus.points = 4'b0001; bus.LEs = 4'b0000; bus.blink = 4'b0000;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy busy=%b required 1", bus.busy);
        end
        while (frame !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL load_wait cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
        end
        checks++;
        if (frame !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_busy frame=%b busy=%b required 1 0", frame, bus.busy);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL commit_frame cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            for (int d = 0; d < 4; d++)
                if (AN === ~(4'b0001 << d) && SEGMENT === want[d]) lit[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != 15) begin
                errors++;
                $display("FAIL commit_digit%0d lit %0d cycles required 15", d, lit[d]);
            end
        end
    endtask

    task automatic test_load_on_frame_end();
        bus.bright = 2'd3; bus.points = 4'b0000; bus.LEs = 4'b0000; bus.blink = 4'b0000;
        advance_to(10);
        bus.hexs = 16'h5555; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        advance_to(FRAME - 1);
        bus.hexs = 16'hAAAA; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL boundary_busy busy=%b required 1", bus.busy);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL boundary_run cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            if (i == 5) begin
                checks++;
                if (SEGMENT !== 8'h92) begin
                    errors++;
                    $display("FAIL boundary_old SEG=%h required 92", SEGMENT);
                end
            end
            if (i == FRAME + 5) begin
                checks++;
                if (SEGMENT !== 8'h88) begin
                    errors++;
                    $display("FAIL boundary_new SEG=%h required 88", SEGMENT);
                end
            end
            if (i == FRAME - 2 || i == FRAME - 1) begin
                checks++;
                if (bus.busy !== (i == FRAME - 2)) begin
                    errors++;
                    $display("FAIL boundary_busy_clear i=%0d busy=%b", i, bus.busy);
                end
            end
        end
    endtask

    task automatic test_brightness();
        int lit [4] = '{0, 0, 0, 0};
        int anyLit = 0;
        bus.bright = 2'd1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL bright1 cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            for (int d = 0; d < 4; d++)
                if (AN === ~(4'b0001 << d)) lit[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != 4) begin
                errors++;
                $display("FAIL bright1_digit%0d lit %0d cycles required 4", d, lit[d]);
            end
        end
        bus.bright = 2'd0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (AN !== 4'hF) anyLit++;
        end
        checks++;
        if (anyLit != 0) begin
            errors++;
            $display("FAIL bright0 lit %0d cycles required 0", anyLit);
        end
    endtask

    task automatic test_blink_blank();
        int lit [4] = '{0, 0, 0, 0};
        int need [4] = '{120, 60, 120, 0};
        int n = 0;
        bus.bright = 2'd3;
        bus.hexs = 16'($urandom); bus.points = 4'($urandom);
        bus.LEs = 4'b1000; bus.blink = 4'b0010; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        while (frame !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL blink_run cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            for (int d = 0; d < 4; d++)
                if (AN === ~(4'b0001 << d)) lit[d]++;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lit[d] != need[d]) begin
                errors++;
                $display("FAIL blink_digit%0d lit %0d cycles required %0d", d, lit[d], need[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bus.bright = 2'd3;
        while (!(mPhase && (cyc % FRAME) == 20) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        bus.hexs = 16'($urandom); bus.points = 4'hF; bus.LEs = 4'h0; bus.blink = 4'hF;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || !mPhase) begin
            errors++;
            $display("FAIL mid_setup busy=%b phase=%b required 1 1", bus.busy, mPhase);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || AN !== 4'hF || SEGMENT !== 8'hFF) begin
            errors++;
            $display("FAIL mid_reset busy=%b AN=%h SEG=%h required 0 F FF", bus.busy, AN, SEGMENT);
        end
        rst = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL mid_run cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            if (i == 5) begin
                checks++;
                if (AN !== 4'hE || SEGMENT !== 8'hC0) begin
                    errors++;
                    $display("FAIL mid_cleared AN=%h SEG=%h required E C0", AN, SEGMENT);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if (AN !== expAn || SEGMENT !== expSeg || frame !== expFrame || bus.busy !== mBusy) begin
                errors++;
                $display("FAIL random cyc=%0d AN=%h/%h SEG=%h/%h frame=%b/%b busy=%b/%b",
                         cyc, AN, expAn, SEGMENT, expSeg, frame, expFrame, bus.busy, mBusy);
            end
            bus.load = ($urandom_range(0, 15) == 0);
            bus.hexs = 16'($urandom); bus.points = 4'($urandom);
            bus.LEs = 4'($urandom); bus.blink = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.bright = 2'($urandom);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.hexs = '0; bus.points = '0; bus.LEs = '0; bus.blink = '0;
        bus.load = 1'b0; bus.bright = '0;
        test_reset();
        test_load_commit();
        test_load_on_frame_end();
        test_brightness();
        test_blink_blank();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised N-digit time-multiplexed 7-segment display driver; successor to the fixed 4-digit scan display path.
- Adds double-buffered tear-free updates, per-digit blink, and PWM brightness control.
- Sits between the top-level board I/O (AN/SEGMENT pins) and any producer of hex digit data.
- Contains its own prescaler, so no external clock divider is needed.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- SCAN_LOG2, 17, log2 of clk cycles per digit slot (prescaler width, ≥ BRIGHT_W+1).
- BRIGHT_W, 3, brightness control width.
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- hexs  input  4*DIGITS  digit values; digit i = hexs[4i+3:4i].
- points  input  DIGITS  decimal point on per digit (1 = lit).
- LEs  input  DIGITS  per-digit blank (1 = blank).
- blink  input  DIGITS  per-digit blink enable.
- load  input  1  1-cycle strobe: capture hexs/points/LEs/blink into pending buffer.
- bright  input  BRIGHT_W  brightness level, sampled live every cycle (not buffered).
- busy  output  1  pending buffer not yet committed.
- frame  output  1  1-cycle pulse at each frame boundary.
- AN  output  DIGITS  digit anodes, active-low, one-hot-low or all-1.
- SEGMENT  output  8  {p,g,f,e,d,c,b,a}, active-low (bit0 = a, bit7 = p).

Behaviour:
- Reset (rst=0 at edge):
  - prescaler=0, digit index=0, blink phase=0, blink frame count=0.
  - display and pending registers cleared (hex 0, points 0, LEs 0, blink 0).
  - busy=0, frame=0, AN all 1, SEGMENT=8'hFF.
  - Reset mid-operation discards any pending load.
- Prescaler:
  - SCAN_LOG2-bit free-running counter.
  - slot_end when prescaler == all ones; prescaler then wraps to 0.
- Digit index:
  - Increments on slot_end, wrapping DIGITS-1 → 0; non-power-of-two DIGITS wraps explicitly.
  - frame_end = slot_end with index==DIGITS-1.
  - frame is a registered pulse asserted the cycle after frame_end.
- Double buffer:
  - load=1: pending <= inputs; busy <= 1.
  - frame_end with busy=1: display <= pending; busy <= 0.
  - load on the same cycle as frame_end: the new inputs go to pending, busy stays 1, and the previous pending is committed. The new data commits at the next frame.
  - load while busy: overwrites pending (last write wins).
- Brightness:
  - duty_on = (bright == all ones) OR (prescaler[SCAN_LOG2-1 -: BRIGHT_W] < bright).
  - bright=0 → digits always dark.
  - bright=all ones → 100% on.
  - Otherwise on-fraction = bright/2^BRIGHT_W of each slot.
- Blink:
  - Frame counter counts frame_end events; at BLINK_FRAMES-1 it wraps and toggles the blink phase.
  - Digit i is blanked when blink[i] (display copy) and phase=1.
- Digit visible = duty_on AND NOT LEs[i] AND NOT (blink[i] AND phase).
  - Visible: AN = ~(1<<i); SEGMENT = {~points[i], decode(hex[i])}.
  - Not visible: AN all 1, SEGMENT 8'hFF.
- Outputs are registered: AN/SEGMENT reflect index/prescaler state with 1-cycle latency.
- An all-1 AN must occur for ≥1 cycle on every index change (anti-ghosting). This is guaranteed because duty_on is forced 0 when prescaler==all ones, unless bright is all ones; in that case AN is forced all 1 on the slot_end cycle.
- Decode, active-low {g..a}:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=8'hFF.
  - 16-entry hex→segment constant table.
  - Segment bit-index constants a..p.
- Sub-module seg7_hex_decode: combinational 4-bit hex + point → 8-bit active-low segments, using the table.
- Top holds prescaler, scan counter, buffers, blink and PWM logic.

Test Plan (DIGITS=4, SCAN_LOG2=4, BRIGHT_W=2, BLINK_FRAMES=2):
- Reset:
  - Stimulus: hold rst=0 for 3 cycles, then release.
  - Required: AN=4'hF, SEGMENT=8'hFF, busy=0 until release. First frame pulse appears 64 cycles after release.
- Load/commit:
  - Stimulus: bright=3, load hexs=16'h1234, points=4'b0001 mid-frame.
  - Required: busy=1 until frame_end, then busy=0. Next frame shows digit0=8'h19 (4, with point lit), digit1=8'hB0, digit2=8'hA4, digit3=8'hF9, each with AN=~(1<<i) for 15 of 16 cycles.
- Load on frame_end:
  - Stimulus: load 16'hAAAA on the frame_end cycle while pending 16'h5555 is held.
  - Required: 5555 displayed this frame, AAAA the following frame, busy remains 1 across the boundary.
- Brightness:
  - Stimulus: bright=1, then bright=0.
  - Required: bright=1 → each digit lit 4/16 slot cycles (prescaler top bits ==0). bright=0 → AN stays 4'hF for the whole frame.
- Blink and blank:
  - Stimulus: blink=4'b0010, LEs=4'b1000, bright=3.
  - Required: digit1 lit for 2 frames, dark for 2 frames, repeating. Digit3 never lit. Digits 0 and 2 always lit.
- Reset mid-operation:
  - Stimulus: assert rst=0 while busy=1 and phase=1.
  - Required: busy=0, phase=0, display cleared (digits show 8'hC0, i.e. 0, after reset, with bright=3).
